regfile_ctrl: RTL
=================

# regfile_ctrl

Controller for the 32×32 integer register file (`dual_read_port_ram_32x32`).
- Clears all 32 entries after reset.
- Keeps x0 hard-wired to zero.
- Forwards same-cycle writes to both read ports, because the RAM returns the old value when a read and a write hit the same address.
- Shares the single write port and read port 1 between core writeback and a debug access port.

It sits between the core's decode/writeback stages and the register-file RAM.

## Interface
Parameters:
- `BYPASS`, 1: enables write-to-read forwarding on both read ports.
- `INIT_CLEAR`, 1: when 1, runs the 32-cycle clear sequence after reset; when 0, `o_init_done` rises on the first cycle after reset.

Ports:
- `clk` in 1: clock; all logic on the rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `i_raddr1`, `i_raddr2` in 5 each: core read addresses.
- `o_rdata1`, `o_rdata2` out 32 each: core read data, 1-cycle latency.
- `i_wb_we` in 1: core writeback enable.
- `i_wb_waddr` in 5: core writeback address.
- `i_wb_wdata` in 32: core writeback data.
- `i_core_halt` in 1: core halted; debug access permitted.
- `i_dbg_req` in 1: debug request, held until granted.
- `i_dbg_we` in 1: 1 = debug write, 0 = debug read.
- `i_dbg_addr` in 5: debug register index.
- `i_dbg_wdata` in 32: debug write data.
- `o_dbg_gnt` out 1: request accepted this cycle (combinational).
- `o_dbg_rvalid` out 1: debug read data valid.
- `o_dbg_rdata` out 32: debug read data.
- `o_init_done` out 1: clear sequence complete.

## Operation
State machine with two states, INIT and RUN.

- **Reset:** asserting `rst_n` low (at any time, including mid-sequence or mid-access) forces INIT, sets the counter to 0 and sets `o_dbg_rvalid` to 0.

- **INIT** (`INIT_CLEAR=1`):
  - Write port driven with address = counter, data = 0, we = 1.
  - Counter increments 0→31.
  - After the counter=31 write, transition to RUN.
  - Core writes are dropped and debug requests are not granted.
- **INIT** (`INIT_CLEAR=0`): INIT lasts one cycle, with no writes.

- **RUN, write-port arbitration:**
  - Core writeback always wins.
  - A debug write is granted only when `i_core_halt=1` and `i_wb_we=0`.
  - Any write with address 0 is suppressed: RAM we = 0, and it is not a bypass source.

- **RUN, debug read:**
  - Granted when `i_core_halt=1`, independent of `i_wb_we`.
  - In the grant cycle, read port 1 address is muxed to `i_dbg_addr`.
- Back-to-back debug accesses are allowed, one per cycle.

- **Bypass** (`BYPASS=1`):
  - Per port, register two things: hit = (effective write enable) && (waddr == raddr) && (raddr ≠ 0), and the write data.
  - The output is the registered write data when hit is set, otherwise the RAM data.
- **x0 reads:** a registered flag forces the output to 0 when the read address was 0.

- **Debug read data:** `o_dbg_rdata` equals the final (bypassed and zero-forced) port-1 data. It is meaningful only while `o_dbg_rvalid=1`.

## Timing
- **Reset values:**
  - `o_rdata1` = `o_rdata2` = 0
  - `o_dbg_rdata` = 0
  - `o_dbg_rvalid` = 0
  - `o_init_done` = 0
  - `o_dbg_gnt` = 0 while in reset or INIT
- **Core reads:** address in cycle N, data in N+1.
- **Writes:** a write in cycle N is visible to a read issued in N (via bypass) or in N+1 (via the RAM).
- **Clear sequence:**
  - `o_init_done` rises in the cycle after the counter=31 write.
  - That is 32 cycles after reset release, with the first clock edge = cycle 0.
  - `o_init_done` stays 1 until the next reset.
- **Debug write:** granted in cycle N, committed at the end of N.
- **Debug read:** granted in N; `o_dbg_rvalid` = 1 for exactly one cycle, N+1, with the data.
- **Simultaneous core write and debug write:** `o_dbg_gnt` = 0 and the request stays pending.
- **Simultaneous write and debug read to the same address:** the debug read returns the new data (bypass).
- **`i_core_halt` deasserting while a request is pending:** no grant is issued.
- **`BYPASS=0`:** a same-cycle write/read to the same address returns old data. This is documented hazard behaviour.

## Structure
- Shared package `regfile_pkg`:
  - `ctrl_state_e` enum, {INIT, RUN}.
  - Constant `NREGS = 32`.
  - `reg_addr_t` (5 bits) and `reg_data_t` (32 bits) typedefs.
- Single sub-module: one instance of `dual_read_port_ram_32x32`.
- The FSM, counter, arbitration muxes, bypass registers and x0 logic are local to `regfile_ctrl`.

## Test plan
- **Reset then idle 40 cycles:** `o_init_done` rises at cycle 32; reading every address returns 0.
- **Bypass check:** write x5=0xDEADBEEF with `i_raddr1=i_raddr2=5` in the same cycle → both ports read 0xDEADBEEF next cycle. Repeat with `BYPASS=0` → both read 0.
- **x0 protection:** write x0=0x12345678 with `i_raddr1=0` → reads 0 next cycle and on every later read.
- **Write contention:** halted core, debug write x7=0xA5A5A5A5 in the same cycle as core wb x3=1 → `o_dbg_gnt=0`, x3=1. Next cycle, with no wb → grant, and a later read of x7 returns 0xA5A5A5A5.
- **Debug read:** halted, debug read x3 → `o_dbg_gnt=1` in N, `o_dbg_rvalid=1` only in N+1 with `o_dbg_rdata=1`. With `i_core_halt=0`, the request is never granted.
- **Mid-sequence reset:** assert `rst_n` low at counter=10 → outputs return to reset values at once. After release, the clear restarts from 0 and `o_init_done` rises 32 cycles later.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared types and constants for the integer register-file controller.
package regfile_pkg;

  localparam int NREGS = 32;

  typedef logic [4:0]  reg_addr_t;
  typedef logic [31:0] reg_data_t;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } ctrl_state_e;

endpackage

// File: rtl/regfile_ctrl_ram.sv
// 32x32 register-file RAM: one write port, two synchronous read ports.
// A read and a write to the same address in one cycle return the old value.
module dual_read_port_ram_32x32
  import regfile_pkg::*;
(
  input  logic      clk,
  input  logic      we,
  input  reg_addr_t waddr,
  input  reg_data_t wdata,
  input  reg_addr_t raddr1,
  output reg_data_t rdata1,
  input  reg_addr_t raddr2,
  output reg_data_t rdata2
);

  reg_data_t mem [NREGS];

  // Write port and registered read ports; reads sample the pre-write contents.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    rdata1 <= mem[raddr1];
    rdata2 <= mem[raddr2];
  end

endmodule

// File: rtl/regfile_ctrl.sv
// Register-file controller: post-reset clear, x0 hard-wiring, write-to-read
// forwarding, and sharing of the write port / read port 1 with debug access.
module regfile_ctrl
  import regfile_pkg::*;
#(
  parameter bit BYPASS     = 1'b1,
  parameter bit INIT_CLEAR = 1'b1
) (
  input  logic      clk,
  input  logic      rst_n,
  input  reg_addr_t i_raddr1,
  input  reg_addr_t i_raddr2,
  output reg_data_t o_rdata1,
  output reg_data_t o_rdata2,
  input  logic      i_wb_we,
  input  reg_addr_t i_wb_waddr,
  input  reg_data_t i_wb_wdata,
  input  logic      i_core_halt,
  input  logic      i_dbg_req,
  input  logic      i_dbg_we,
  input  reg_addr_t i_dbg_addr,
  input  reg_data_t i_dbg_wdata,
  output logic      o_dbg_gnt,
  output logic      o_dbg_rvalid,
  output reg_data_t o_dbg_rdata,
  output logic      o_init_done
);

  ctrl_state_e state, state_nxt;
  reg_addr_t   cnt, cnt_nxt;

  logic        dbg_wr_gnt, dbg_rd_gnt;
  logic        wr_en, ram_we;
  reg_addr_t   ram_waddr, ram_raddr1;
  reg_data_t   ram_wdata, ram_rdata1, ram_rdata2;
  logic        hit1, hit2;

  logic        hit1_p1, hit2_p1, zero1_p1, zero2_p1, dbg_vld_p1;
  reg_data_t   byp1_p1, byp2_p1;

  // Final read data: x0 forces zero, a forwarded write beats the stale RAM word.
  function automatic reg_data_t fwd_select(input logic      zero,
                                           input logic      hit,
                                           input reg_data_t byp,
                                           input reg_data_t ram);
    reg_data_t res;
    if (zero)     res = '0;
    else if (hit) res = byp;
    else          res = ram;
    return res;
  endfunction

  // State register and clear counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= INIT;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next state, clear-sequence writes and write/read-port arbitration.
  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    dbg_wr_gnt = 1'b0;
    dbg_rd_gnt = 1'b0;
    wr_en      = 1'b0;
    ram_waddr  = i_wb_waddr;
    ram_wdata  = i_wb_wdata;
    ram_raddr1 = i_raddr1;
    case (state)
      INIT: begin
        if (INIT_CLEAR) begin
          wr_en     = 1'b1;
          ram_waddr = cnt;
          ram_wdata = '0;
          cnt_nxt   = cnt + 5'd1;
          if (cnt == 5'(NREGS - 1)) begin
            state_nxt = RUN;
          end
        end else begin
          state_nxt = RUN;
        end
      end
      RUN: begin
        // Debug reads only borrow read port 1, so writeback does not block them.
        dbg_rd_gnt = i_core_halt & i_dbg_req & ~i_dbg_we;
        dbg_wr_gnt = i_core_halt & i_dbg_req & i_dbg_we & ~i_wb_we;
        if (i_wb_we) begin
          wr_en = 1'b1;
        end else if (dbg_wr_gnt) begin
          wr_en     = 1'b1;
          ram_waddr = i_dbg_addr;
          ram_wdata = i_dbg_wdata;
        end
        if (dbg_rd_gnt) begin
          ram_raddr1 = i_dbg_addr;
        end
      end
    endcase
  end

  // Writes to x0 never reach the RAM and never forward.
  assign ram_we = wr_en && (ram_waddr != '0);
  assign hit1   = BYPASS && ram_we && (ram_waddr == ram_raddr1);
  assign hit2   = BYPASS && ram_we && (ram_waddr == i_raddr2);

  // Stage p1 control: forward hits, x0 flags and debug-read valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit1_p1    <= 1'b0;
      hit2_p1    <= 1'b0;
      zero1_p1   <= 1'b1;
      zero2_p1   <= 1'b1;
      dbg_vld_p1 <= 1'b0;
    end else begin
      hit1_p1    <= hit1;
      hit2_p1    <= hit2;
      zero1_p1   <= (ram_raddr1 == '0);
      zero2_p1   <= (i_raddr2 == '0);
      dbg_vld_p1 <= dbg_rd_gnt;
    end
  end

  // Stage p1 data: forwarded write word, only consumed when the hit flag is set.
  always_ff @(posedge clk) begin
    byp1_p1 <= ram_wdata;
    byp2_p1 <= ram_wdata;
  end

  dual_read_port_ram_32x32 u_ram (
    .clk    (clk),
    .we     (ram_we),
    .waddr  (ram_waddr),
    .wdata  (ram_wdata),
    .raddr1 (ram_raddr1),
    .rdata1 (ram_rdata1),
    .raddr2 (i_raddr2),
    .rdata2 (ram_rdata2)
  );

  assign o_rdata1     = fwd_select(zero1_p1, hit1_p1, byp1_p1, ram_rdata1);
  assign o_rdata2     = fwd_select(zero2_p1, hit2_p1, byp2_p1, ram_rdata2);
  assign o_dbg_rdata  = o_rdata1;
  assign o_dbg_rvalid = dbg_vld_p1;
  assign o_dbg_gnt    = dbg_wr_gnt | dbg_rd_gnt;
  assign o_init_done  = (state == RUN);

endmodule
